rv32i_ex_cluster: RTL and testbench
===================================

# rv32i_ex_cluster

RV32I execute-side compute cluster for the 5-stage pipeline core. It combines three functions: main control decode of the IF/ID instruction, forwarding and load-use hazard detection, and the EX-stage ALU with its operand muxing. It sits between the ID/EX pipeline register and the memory stage, and registers the EX results that feed EX/MEM.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears registered outputs only
- if_id_instr  in  32  instruction in ID; source of decode and hazard rs fields [19:15]/[24:20]
- RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, Branch, Jump  out  1 each  decoded controls (comb)
- ALUOp  out  2  00 add, 01 branch, 10 funct-decoded, 11 LUI/AUIPC/JAL/JALR
- id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm  in  32 each  ID/EX operands
- id_ex_rs1, id_ex_rs2, id_ex_rd  in  5 each  ID/EX register indices
- id_ex_opcode  in  7;  id_ex_funct3  in  3;  id_ex_funct7  in  7
- id_ex_ALUSrc, id_ex_Branch, id_ex_Jump, id_ex_MemRead  in  1 each;  id_ex_ALUOp  in  2
- ex_mem_RegWrite  in  1;  ex_mem_rd  in  5;  ex_mem_fwd_data  in  32  EX/MEM ALU result
- mem_wb_RegWrite  in  1;  mem_wb_rd  in  5;  mem_wb_fwd_data  in  32  WB value (already MemToReg-muxed)
- forwardA, forwardB  out  2 each  00 none, 10 from EX/MEM, 01 from MEM/WB
- stall  out  1  load-use hazard
- alu_result  out  32;  alu_zero  out  1  (comb)
- ex_alu_out_q, ex_store_data_q, ex_branch_target_q  out  32 each;  ex_branch_taken_q  out  1  (registered)

## Operation
- Decode by opcode (unlisted opcodes drive all controls to 0, ALUOp=00):
  - 0110011 R: RegWrite, ALUOp=10.
  - 0010011 I-ALU: RegWrite, ALUSrc, ALUOp=10.
  - 0000011 load: RegWrite, MemRead, MemToReg, ALUSrc, ALUOp=00.
  - 0100011 store: MemWrite, ALUSrc, ALUOp=00.
  - 1100011 branch: Branch, ALUOp=01.
  - 1101111 JAL: RegWrite, Jump, ALUOp=11.
  - 1100111 JALR: RegWrite, Jump, ALUSrc, ALUOp=11.
  - 0110111 LUI and 0010111 AUIPC: RegWrite, ALUSrc, ALUOp=11.
- Forwarding (A uses id_ex_rs1, B uses id_ex_rs2):
  - 10 when ex_mem_RegWrite, ex_mem_rd!=0 and ex_mem_rd matches.
  - Otherwise 01 when the same conditions hold for the mem_wb signals.
  - Otherwise 00. EX/MEM has priority.
- stall = id_ex_MemRead & id_ex_rd!=0 & (id_ex_rd==if_id_instr[19:15] | id_ex_rd==if_id_instr[24:20]).
- Operand muxing:
  - fwdA and fwdB are the forwarded rs1 and rs2 values.
  - in1 = fwdA. in2 = id_ex_imm if id_ex_ALUSrc, else fwdB.
  - AUIPC: in1=id_ex_pc. LUI: in1=0. In both cases in2=imm.
- ALU op by ALUOp:
  - 00: add. 01: sub. 11: add.
  - 10, by funct3: 000 add (sub only when opcode is R and funct7[5]=1); 111 and; 110 or; 100 xor; 001 sll; 101 srl, or sra when funct7[5]=1; 010 slt (signed); 011 sltu.
  - Shifts use in2[4:0]. Arithmetic wraps mod 2^32.
  - alu_zero = (alu_result==0).
- Jump overrides: when id_ex_Jump, alu_result = id_ex_pc+4 (link value).
- Branch condition uses fwdA and fwdB, by funct3:
  - 000 eq, 001 ne, 100 lt (signed), 101 ge (signed), 110 ltu, 111 geu.
  - Any other funct3 is not taken.
- Branch target:
  - JAL and branches: id_ex_pc+id_ex_imm.
  - JALR: (fwdA+id_ex_imm) with bit 0 cleared.

## Timing
- Decode, forwarding, stall, ALU, alu_zero: purely combinational, same cycle, unaffected by reset.
- On each rising clk:
  - ex_alu_out_q ← alu_result.
  - ex_store_data_q ← fwdB (forwarded rs2, never imm).
  - ex_branch_taken_q ← (id_ex_Branch & cond) | id_ex_Jump.
  - ex_branch_target_q ← target.
  - Latency is 1 cycle.
- reset=1 at a clk edge: all four registered outputs become 0, overriding inputs. Reset asserted mid-flow drops the in-flight EX result; the first post-reset edge captures normally.
- Registers update every cycle, including during stall. The bubble is inserted upstream, so the block captures whatever ID/EX presents.
- rd=0 never forwards and never stalls. If ex_mem and mem_wb both match, EX/MEM wins.

## Test plan
- ADD/SUB and decode:
  - if_id_instr=0x002081B3 (add x3,x1,x2) → RegWrite=1, ALUOp=10, ALUSrc=0.
  - R-type, funct7=0x20, in1=5, in2=7 → alu_result=0xFFFFFFFE; ex_alu_out_q equals it one edge later.
- Shifts/compare:
  - sra in1=0x80000000, in2=4 → 0xF8000000.
  - sltu in1=1, in2=0xFFFFFFFF → 1.
  - slt with the same operands → 0.
- Forwarding priority: ex_mem_rd=mem_wb_rd=id_ex_rs1=5, both RegWrite=1 → forwardA=10, in1=ex_mem_fwd_data. With rd=0 on both → forwardA=00.
- Load-use: id_ex_MemRead=1, id_ex_rd=3, if_id_instr rs2=3 → stall=1. With id_ex_rd=0 → stall=0.
- Branch/jump:
  - beq, fwdA==fwdB, pc=0x100, imm=0x20 → ex_branch_taken_q=1, target=0x120.
  - bne with equal operands → not taken.
  - JALR, rs1=0x203, imm=0 → target=0x202, ex_alu_out_q=pc+4.
- Reset: registered outputs nonzero, reset=1 at one edge → all read 0 after that edge; combinational outputs keep tracking their inputs.

Source files
------------

// File: rtl/rv32i_ex_cluster.sv
// RV32I execute-side cluster: main control decode, forwarding and load-use
// detection, and the EX-stage ALU / branch unit registered into EX/MEM.
module rv32i_ex_cluster #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,

    input  logic [31:0]     if_id_instr,
    output logic            RegWrite,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            MemToReg,
    output logic            ALUSrc,
    output logic            Branch,
    output logic            Jump,
    output logic [1:0]      ALUOp,

    input  logic [XLEN-1:0] id_ex_pc,
    input  logic [XLEN-1:0] id_ex_rs1_data,
    input  logic [XLEN-1:0] id_ex_rs2_data,
    input  logic [XLEN-1:0] id_ex_imm,
    input  logic [4:0]      id_ex_rs1,
    input  logic [4:0]      id_ex_rs2,
    input  logic [4:0]      id_ex_rd,
    input  logic [6:0]      id_ex_opcode,
    input  logic [2:0]      id_ex_funct3,
    input  logic [6:0]      id_ex_funct7,
    input  logic            id_ex_ALUSrc,
    input  logic            id_ex_Branch,
    input  logic            id_ex_Jump,
    input  logic            id_ex_MemRead,
    input  logic [1:0]      id_ex_ALUOp,

    input  logic            ex_mem_RegWrite,
    input  logic [4:0]      ex_mem_rd,
    input  logic [XLEN-1:0] ex_mem_fwd_data,
    input  logic            mem_wb_RegWrite,
    input  logic [4:0]      mem_wb_rd,
    input  logic [XLEN-1:0] mem_wb_fwd_data,

    output logic [1:0]      forwardA,
    output logic [1:0]      forwardB,
    output logic            stall,

    output logic [XLEN-1:0] alu_result,
    output logic            alu_zero,

    output logic [XLEN-1:0] ex_alu_out_q,
    output logic [XLEN-1:0] ex_store_data_q,
    output logic [XLEN-1:0] ex_branch_target_q,
    output logic            ex_branch_taken_q
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] FWD_WB   = 2'b01;

    logic [4:0]      if_id_rs1;
    logic [4:0]      if_id_rs2;
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] alu_in1;
    logic [XLEN-1:0] alu_in2;
    logic [XLEN-1:0] alu_core;
    logic [4:0]      shamt;
    logic            alt_op;
    logic            branch_cond;
    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] jalr_sum;
    logic            branch_taken;

    assign if_id_rs1 = if_id_instr[19:15];
    assign if_id_rs2 = if_id_instr[24:20];

    // Main control decode of the instruction currently in ID.
    always_comb begin
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemToReg = 1'b0;
        ALUSrc   = 1'b0;
        Branch   = 1'b0;
        Jump     = 1'b0;
        ALUOp    = 2'b00;
        case (if_id_instr[6:0])
            OP_R: begin
                RegWrite = 1'b1;
                ALUOp    = 2'b10;
            end
            OP_I_ALU: begin
                RegWrite = 1'b1;
                ALUSrc   = 1'b1;
                ALUOp    = 2'b10;
            end
            OP_LOAD: begin
                RegWrite = 1'b1;
                MemRead  = 1'b1;
                MemToReg = 1'b1;
                ALUSrc   = 1'b1;
            end
            OP_STORE: begin
                MemWrite = 1'b1;
                ALUSrc   = 1'b1;
            end
            OP_BRANCH: begin
                Branch   = 1'b1;
                ALUOp    = 2'b01;
            end
            OP_JAL: begin
                RegWrite = 1'b1;
                Jump     = 1'b1;
                ALUOp    = 2'b11;
            end
            OP_JALR: begin
                RegWrite = 1'b1;
                Jump     = 1'b1;
                ALUSrc   = 1'b1;
                ALUOp    = 2'b11;
            end
            OP_LUI, OP_AUIPC: begin
                RegWrite = 1'b1;
                ALUSrc   = 1'b1;
                ALUOp    = 2'b11;
            end
            default: ;
        endcase
    end

    // Forwarding select; the younger EX/MEM result wins over MEM/WB.
    always_comb begin
        forwardA = FWD_NONE;
        if (ex_mem_RegWrite && (ex_mem_rd != 5'd0) && (ex_mem_rd == id_ex_rs1))
            forwardA = FWD_MEM;
        else if (mem_wb_RegWrite && (mem_wb_rd != 5'd0) && (mem_wb_rd == id_ex_rs1))
            forwardA = FWD_WB;
    end

    always_comb begin
        forwardB = FWD_NONE;
        if (ex_mem_RegWrite && (ex_mem_rd != 5'd0) && (ex_mem_rd == id_ex_rs2))
            forwardB = FWD_MEM;
        else if (mem_wb_RegWrite && (mem_wb_rd != 5'd0) && (mem_wb_rd == id_ex_rs2))
            forwardB = FWD_WB;
    end

    assign stall = id_ex_MemRead && (id_ex_rd != 5'd0) &&
                   ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

    always_comb begin
        case (forwardA)
            FWD_MEM: fwd_a = ex_mem_fwd_data;
            FWD_WB:  fwd_a = mem_wb_fwd_data;
            default: fwd_a = id_ex_rs1_data;
        endcase
    end

    always_comb begin
        case (forwardB)
            FWD_MEM: fwd_b = ex_mem_fwd_data;
            FWD_WB:  fwd_b = mem_wb_fwd_data;
            default: fwd_b = id_ex_rs2_data;
        endcase
    end

    // AUIPC and LUI bypass the register operands entirely.
    always_comb begin
        alu_in1 = fwd_a;
        alu_in2 = id_ex_ALUSrc ? id_ex_imm : fwd_b;
        if (id_ex_opcode == OP_AUIPC) begin
            alu_in1 = id_ex_pc;
            alu_in2 = id_ex_imm;
        end else if (id_ex_opcode == OP_LUI) begin
            alu_in1 = '0;
            alu_in2 = id_ex_imm;
        end
    end

    assign shamt  = alu_in2[4:0];
    assign alt_op = id_ex_funct7[5];

    always_comb begin
        alu_core = '0;
        case (id_ex_ALUOp)
            2'b00: alu_core = alu_in1 + alu_in2;
            2'b01: alu_core = alu_in1 - alu_in2;
            2'b11: alu_core = alu_in1 + alu_in2;
            default: begin
                case (id_ex_funct3)
                    3'b000: alu_core = (id_ex_opcode == OP_R && alt_op) ?
                                       (alu_in1 - alu_in2) : (alu_in1 + alu_in2);
                    3'b111: alu_core = alu_in1 & alu_in2;
                    3'b110: alu_core = alu_in1 | alu_in2;
                    3'b100: alu_core = alu_in1 ^ alu_in2;
                    3'b001: alu_core = alu_in1 << shamt;
                    3'b101: alu_core = alt_op ? XLEN'($signed(alu_in1) >>> shamt)
                                              : (alu_in1 >> shamt);
                    3'b010: alu_core = {{(XLEN-1){1'b0}},
                                        ($signed(alu_in1) < $signed(alu_in2))};
                    default: alu_core = {{(XLEN-1){1'b0}}, (alu_in1 < alu_in2)};
                endcase
            end
        endcase
    end

    // Jumps write the link address instead of the ALU value.
    assign alu_result = id_ex_Jump ? (id_ex_pc + XLEN'(4)) : alu_core;
    assign alu_zero   = (alu_result == '0);

    always_comb begin
        case (id_ex_funct3)
            3'b000:  branch_cond = (fwd_a == fwd_b);
            3'b001:  branch_cond = (fwd_a != fwd_b);
            3'b100:  branch_cond = ($signed(fwd_a) < $signed(fwd_b));
            3'b101:  branch_cond = ($signed(fwd_a) >= $signed(fwd_b));
            3'b110:  branch_cond = (fwd_a < fwd_b);
            3'b111:  branch_cond = (fwd_a >= fwd_b);
            default: branch_cond = 1'b0;
        endcase
    end

    assign jalr_sum      = fwd_a + id_ex_imm;
    assign branch_target = (id_ex_opcode == OP_JALR) ? {jalr_sum[XLEN-1:1], 1'b0}
                                                     : (id_ex_pc + id_ex_imm);
    assign branch_taken  = (id_ex_Branch && branch_cond) || id_ex_Jump;

    // Registers capture every cycle; bubbles are inserted upstream on stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_alu_out_q       <= '0;
            ex_store_data_q    <= '0;
            ex_branch_target_q <= '0;
            ex_branch_taken_q  <= 1'b0;
        end else begin
            ex_alu_out_q       <= alu_result;
            ex_store_data_q    <= fwd_b;
            ex_branch_target_q <= branch_target;
            ex_branch_taken_q  <= branch_taken;
        end
    end

    logic unused_instr_bits;
    assign unused_instr_bits = ^{if_id_instr[31:25], if_id_instr[14:7],
                                 id_ex_funct7[6], id_ex_funct7[4:0]};

endmodule

// File: tb/tb_rv32i_ex_cluster.sv
// Directed testbench for rv32i_ex_cluster: decode, forwarding, hazard,
// ALU, branch/jump and reset behaviour against hand-computed values.
module tb_rv32i_ex_cluster;

    logic        clk;
    logic        reset;
    logic [31:0] if_id_instr;
    logic        RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, Branch, Jump;
    logic [1:0]  ALUOp;
    logic [31:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
    logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
    logic [6:0]  id_ex_opcode;
    logic [2:0]  id_ex_funct3;
    logic [6:0]  id_ex_funct7;
    logic        id_ex_ALUSrc, id_ex_Branch, id_ex_Jump, id_ex_MemRead;
    logic [1:0]  id_ex_ALUOp;
    logic        ex_mem_RegWrite;
    logic [4:0]  ex_mem_rd;
    logic [31:0] ex_mem_fwd_data;
    logic        mem_wb_RegWrite;
    logic [4:0]  mem_wb_rd;
    logic [31:0] mem_wb_fwd_data;
    logic [1:0]  forwardA, forwardB;
    logic        stall;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic [31:0] ex_alu_out_q, ex_store_data_q, ex_branch_target_q;
    logic        ex_branch_taken_q;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    rv32i_ex_cluster #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .if_id_instr(if_id_instr),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemToReg(MemToReg), .ALUSrc(ALUSrc), .Branch(Branch), .Jump(Jump),
        .ALUOp(ALUOp),
        .id_ex_pc(id_ex_pc), .id_ex_rs1_data(id_ex_rs1_data),
        .id_ex_rs2_data(id_ex_rs2_data), .id_ex_imm(id_ex_imm),
        .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
        .id_ex_opcode(id_ex_opcode), .id_ex_funct3(id_ex_funct3),
        .id_ex_funct7(id_ex_funct7), .id_ex_ALUSrc(id_ex_ALUSrc),
        .id_ex_Branch(id_ex_Branch), .id_ex_Jump(id_ex_Jump),
        .id_ex_MemRead(id_ex_MemRead), .id_ex_ALUOp(id_ex_ALUOp),
        .ex_mem_RegWrite(ex_mem_RegWrite), .ex_mem_rd(ex_mem_rd),
        .ex_mem_fwd_data(ex_mem_fwd_data),
        .mem_wb_RegWrite(mem_wb_RegWrite), .mem_wb_rd(mem_wb_rd),
        .mem_wb_fwd_data(mem_wb_fwd_data),
        .forwardA(forwardA), .forwardB(forwardB), .stall(stall),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .ex_alu_out_q(ex_alu_out_q), .ex_store_data_q(ex_store_data_q),
        .ex_branch_target_q(ex_branch_target_q),
        .ex_branch_taken_q(ex_branch_taken_q)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        if_id_instr     = 32'h0;
        id_ex_pc        = 32'h0;
        id_ex_rs1_data  = 32'h0;
        id_ex_rs2_data  = 32'h0;
        id_ex_imm       = 32'h0;
        id_ex_rs1       = 5'd0;
        id_ex_rs2       = 5'd0;
        id_ex_rd        = 5'd0;
        id_ex_opcode    = 7'h0;
        id_ex_funct3    = 3'h0;
        id_ex_funct7    = 7'h0;
        id_ex_ALUSrc    = 1'b0;
        id_ex_Branch    = 1'b0;
        id_ex_Jump      = 1'b0;
        id_ex_MemRead   = 1'b0;
        id_ex_ALUOp     = 2'b00;
        ex_mem_RegWrite = 1'b0;
        ex_mem_rd       = 5'd0;
        ex_mem_fwd_data = 32'h0;
        mem_wb_RegWrite = 1'b0;
        mem_wb_rd       = 5'd0;
        mem_wb_fwd_data = 32'h0;
    endtask

    task automatic drive_ex(input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [1:0] aluop,
                            input logic src, input logic br, input logic jmp,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] imm, input logic [31:0] pc);
        id_ex_opcode   = op;
        id_ex_funct3   = f3;
        id_ex_funct7   = f7;
        id_ex_ALUOp    = aluop;
        id_ex_ALUSrc   = src;
        id_ex_Branch   = br;
        id_ex_Jump     = jmp;
        id_ex_rs1_data = a;
        id_ex_rs2_data = b;
        id_ex_imm      = imm;
        id_ex_pc       = pc;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({ex_alu_out_q, ex_store_data_q, ex_branch_target_q, ex_branch_taken_q} !== 97'h0) begin
            n_err++;
            $display("FAIL reset_regs: got %h/%h/%h/%b, expected all zero",
                     ex_alu_out_q, ex_store_data_q, ex_branch_target_q, ex_branch_taken_q);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_decode();
        logic [31:0] instr_tab [10];
        logic [8:0]  ctl_tab [10];
        logic [8:0]  got;
        instr_tab = '{32'h002081B3, 32'h00A08093, 32'h0000A103, 32'h0020A023,
                      32'h00208463, 32'h0000006F, 32'h00008067, 32'h000010B7,
                      32'h00001097, 32'h0000007F};
        // {RegWrite,MemRead,MemWrite,MemToReg,ALUSrc,Branch,Jump,ALUOp}
        ctl_tab   = '{9'b100000010, 9'b100010010, 9'b110110000, 9'b001010000,
                      9'b000001001, 9'b100000111, 9'b100010111, 9'b100010011,
                      9'b100010011, 9'b000000000};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if_id_instr = instr_tab[i];
            #1;
            got = {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, Branch, Jump, ALUOp};
            n_vec++;
            if (got !== ctl_tab[i]) begin
                n_err++;
                $display("FAIL decode[%0d] instr=%h: got %b, expected %b",
                         i, instr_tab[i], got, ctl_tab[i]);
            end
        end
        if_id_instr = 32'h0;
    endtask

    task automatic test_alu();
        logic [6:0]  op  [11];
        logic [2:0]  f3  [11];
        logic [6:0]  f7  [11];
        logic [1:0]  ao  [11];
        logic        src [11];
        logic [31:0] a   [11];
        logic [31:0] b   [11];
        logic [31:0] imm [11];
        logic [31:0] ex  [11];
        op  = '{7'h33, 7'h33, 7'h33, 7'h33, 7'h33, 7'h33, 7'h13, 7'h33, 7'h33, 7'h33, 7'h23};
        f3  = '{3'd0, 3'd0, 3'd5, 3'd5, 3'd3, 3'd2, 3'd0, 3'd7, 3'd1, 3'd4, 3'd2};
        f7  = '{7'h20, 7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00};
        ao  = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
        src = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        a   = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd1, 32'd1, 32'd10,
                32'h0000F0F0, 32'd1, 32'h12345678, 32'h00001000};
        b   = '{32'd7, 32'd7, 32'd4, 32'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hDEAD0000,
                32'h0000FF00, 32'h0000003F, 32'h12345678, 32'hCAFEBABE};
        imm = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'd3, 32'h0, 32'h0, 32'h0, 32'h24};
        ex  = '{32'hFFFFFFFE, 32'd12, 32'hF8000000, 32'h08000000, 32'd1, 32'd0, 32'd13,
                32'h0000F000, 32'h80000000, 32'h0, 32'h00001024};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive_ex(op[i], f3[i], f7[i], ao[i], src[i], 1'b0, 1'b0, a[i], b[i], imm[i], 32'h40);
            #1;
            n_vec++;
            if (alu_result !== ex[i] || alu_zero !== (ex[i] == 32'h0)) begin
                n_err++;
                $display("FAIL alu[%0d]: got %h zero=%b, expected %h zero=%b",
                         i, alu_result, alu_zero, ex[i], ex[i] == 32'h0);
            end
            @(posedge clk);
            #1;
            n_vec++;
            if (ex_alu_out_q !== ex[i] || ex_store_data_q !== b[i] || ex_branch_taken_q !== 1'b0) begin
                n_err++;
                $display("FAIL alu_reg[%0d]: got out=%h st=%h tk=%b, expected out=%h st=%h tk=0",
                         i, ex_alu_out_q, ex_store_data_q, ex_branch_taken_q, ex[i], b[i]);
            end
        end
    endtask

    task automatic test_upper_imm();
        @(negedge clk);
        drive_ex(7'h17, 3'd0, 7'h0, 2'b11, 1'b1, 1'b0, 1'b0, 32'h11111111, 32'h0,
                 32'h00005000, 32'h00001000);
        #1;
        n_vec++;
        if (alu_result !== 32'h00006000) begin
            n_err++;
            $display("FAIL auipc: got %h, expected %h", alu_result, 32'h00006000);
        end
        id_ex_opcode = 7'h37;
        id_ex_imm    = 32'hABCDE000;
        #1;
        n_vec++;
        if (alu_result !== 32'hABCDE000) begin
            n_err++;
            $display("FAIL lui: got %h, expected %h", alu_result, 32'hABCDE000);
        end
    endtask

    task automatic test_forwarding();
        @(negedge clk);
        drive_idle();
        drive_ex(7'h23, 3'd2, 7'h0, 2'b00, 1'b1, 1'b0, 1'b0, 32'h1, 32'h2, 32'h0, 32'h0);
        id_ex_rs1 = 5'd5; id_ex_rs2 = 5'd6;
        ex_mem_RegWrite = 1'b1; ex_mem_rd = 5'd5; ex_mem_fwd_data = 32'hAAAA0001;
        mem_wb_RegWrite = 1'b1; mem_wb_rd = 5'd5; mem_wb_fwd_data = 32'hBBBB0002;
        #1;
        n_vec++;
        if (forwardA !== 2'b10 || alu_result !== 32'hAAAA0001 || forwardB !== 2'b00) begin
            n_err++;
            $display("FAIL fwd_priority: got fA=%b fB=%b res=%h, expected fA=10 fB=00 res=%h",
                     forwardA, forwardB, alu_result, 32'hAAAA0001);
        end
        // rs2 only matches MEM/WB: store data must carry the WB value
        mem_wb_rd = 5'd6;
        #1;
        n_vec++;
        if (forwardA !== 2'b10 || forwardB !== 2'b01) begin
            n_err++;
            $display("FAIL fwd_wb: got fA=%b fB=%b, expected fA=10 fB=01", forwardA, forwardB);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (ex_store_data_q !== 32'hBBBB0002) begin
            n_err++;
            $display("FAIL fwd_store_data: got %h, expected %h", ex_store_data_q, 32'hBBBB0002);
        end
        @(negedge clk);
        ex_mem_RegWrite = 1'b0; mem_wb_rd = 5'd5;
        #1;
        n_vec++;
        if (forwardA !== 2'b01 || alu_result !== 32'hBBBB0002) begin
            n_err++;
            $display("FAIL fwd_ex_off: got fA=%b res=%h, expected fA=01 res=%h",
                     forwardA, alu_result, 32'hBBBB0002);
        end
        ex_mem_RegWrite = 1'b1;
        ex_mem_rd = 5'd0; mem_wb_rd = 5'd0; id_ex_rs1 = 5'd0; id_ex_rs2 = 5'd0;
        #1;
        n_vec++;
        if (forwardA !== 2'b00 || forwardB !== 2'b00 || alu_result !== 32'h1) begin
            n_err++;
            $display("FAIL fwd_rd0: got fA=%b fB=%b res=%h, expected 00 00 %h",
                     forwardA, forwardB, alu_result, 32'h1);
        end
        drive_idle();
    endtask

    task automatic test_load_use();
        logic [31:0] instr_tab [5];
        logic [4:0]  rd_tab [5];
        logic        mr_tab [5];
        logic        st_tab [5];
        instr_tab = '{32'h00300033, 32'h00018033, 32'h00300033, 32'h00300033, 32'h00420033};
        rd_tab    = '{5'd3, 5'd3, 5'd0, 5'd3, 5'd3};
        mr_tab    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        st_tab    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if_id_instr = instr_tab[i]; id_ex_rd = rd_tab[i]; id_ex_MemRead = mr_tab[i];
            #1;
            n_vec++;
            if (stall !== st_tab[i]) begin
                n_err++;
                $display("FAIL stall[%0d]: got %b, expected %b", i, stall, st_tab[i]);
            end
        end
        drive_idle();
    endtask

    task automatic test_branch_jump();
        logic [2:0]  f3 [6];
        logic [31:0] a  [6];
        logic [31:0] b  [6];
        logic        tk [6];
        f3 = '{3'd0, 3'd1, 3'd4, 3'd6, 3'd2, 3'd7};
        a  = '{32'h55, 32'h55, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF};
        b  = '{32'h55, 32'h55, 32'h1, 32'h1, 32'h2, 32'h1};
        tk = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive_ex(7'h63, f3[i], 7'h0, 2'b01, 1'b0, 1'b1, 1'b0, a[i], b[i], 32'h20, 32'h100);
            @(posedge clk);
            #1;
            n_vec++;
            if (ex_branch_taken_q !== tk[i] || ex_branch_target_q !== 32'h120) begin
                n_err++;
                $display("FAIL branch[%0d]: got tk=%b tgt=%h, expected tk=%b tgt=%h",
                         i, ex_branch_taken_q, ex_branch_target_q, tk[i], 32'h120);
            end
        end
        @(negedge clk);
        drive_ex(7'h67, 3'd0, 7'h0, 2'b11, 1'b1, 1'b0, 1'b1, 32'h203, 32'h0, 32'h0, 32'h400);
        @(posedge clk);
        #1;
        n_vec++;
        if (ex_branch_taken_q !== 1'b1 || ex_branch_target_q !== 32'h202 ||
            ex_alu_out_q !== 32'h404) begin
            n_err++;
            $display("FAIL jalr: got tk=%b tgt=%h out=%h, expected tk=1 tgt=%h out=%h",
                     ex_branch_taken_q, ex_branch_target_q, ex_alu_out_q, 32'h202, 32'h404);
        end
        @(negedge clk);
        drive_ex(7'h6F, 3'd0, 7'h0, 2'b11, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'hFFFFFFF0, 32'h800);
        @(posedge clk);
        #1;
        n_vec++;
        if (ex_branch_taken_q !== 1'b1 || ex_branch_target_q !== 32'h7F0 ||
            ex_alu_out_q !== 32'h804) begin
            n_err++;
            $display("FAIL jal: got tk=%b tgt=%h out=%h, expected tk=1 tgt=%h out=%h",
                     ex_branch_taken_q, ex_branch_target_q, ex_alu_out_q, 32'h7F0, 32'h804);
        end
    endtask

    task automatic test_reset_midflow();
        // registered outputs are nonzero from the JAL above
        @(negedge clk);
        reset = 1'b1;
        drive_ex(7'h33, 3'd0, 7'h0, 2'b10, 1'b0, 1'b0, 1'b0, 32'd5, 32'd7, 32'h0, 32'h0);
        #1;
        n_vec++;
        if (alu_result !== 32'd12) begin
            n_err++;
            $display("FAIL reset_comb: got %h, expected %h", alu_result, 32'd12);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({ex_alu_out_q, ex_store_data_q, ex_branch_target_q, ex_branch_taken_q} !== 97'h0) begin
            n_err++;
            $display("FAIL reset_mid: got %h/%h/%h/%b, expected all zero",
                     ex_alu_out_q, ex_store_data_q, ex_branch_target_q, ex_branch_taken_q);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (ex_alu_out_q !== 32'd12 || ex_store_data_q !== 32'd7) begin
            n_err++;
            $display("FAIL reset_release: got out=%h st=%h, expected out=%h st=%h",
                     ex_alu_out_q, ex_store_data_q, 32'd12, 32'd7);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, exp_v;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a = $urandom_range(0, 32'h7FFFFFFF);
            b = $urandom_range(0, 32'h7FFFFFFF);
            if (i[0]) begin
                drive_ex(7'h33, 3'd0, 7'h20, 2'b10, 1'b0, 1'b0, 1'b0, a, b, 32'h0, 32'h0);
                exp_q.push_back(a - b);
            end else begin
                drive_ex(7'h33, 3'd4, 7'h00, 2'b10, 1'b0, 1'b0, 1'b0, a, b, 32'h0, 32'h0);
                exp_q.push_back(a ^ b);
            end
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            n_vec++;
            if (ex_alu_out_q !== exp_v) begin
                n_err++;
                $display("FAIL b2b[%0d]: got %h, expected %h", i, ex_alu_out_q, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_alu();
        test_upper_imm();
        test_forwarding();
        test_load_use();
        test_branch_jump();
        test_reset_midflow();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
